// File: rtl/mdio_rx_frame_if.sv
// mdio_rx_frame_if: serial MDIO lines plus register-file strobes between a station driver and the PHY-side receiver.
interface mdio_rx_frame_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 5,
  parameter int PHY_AW = 5
);
  logic [PHY_AW-1:0] phy_addr;
  logic              mdio_out;
  logic              mdio_oe;
  logic [DATA_W-1:0] rd_data;
  logic [REG_AW-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_stb;
  logic              rd_stb;
  logic              mdio_in;
  logic              mdio_in_oe;
  logic              mdio_done;
  logic              frame_err;
  modport master (
    output phy_addr, mdio_out, mdio_oe, rd_data,
    input  addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err
  );
  modport slave (
    input  phy_addr, mdio_out, mdio_oe, rd_data,
    output addr, wr_data, wr_stb, rd_stb, mdio_in, mdio_in_oe, mdio_done, frame_err
  );
endinterface

// File: rtl/mdio_rx_frame.sv
// mdio_rx_frame: Clause-22 MDIO frame receiver with PHY address filter, register strobes and read-back serialiser.
// Optional MDIO_PRE_SUPPRESS_EN: after an accepted frame, later frames may omit the preamble.
module mdio_rx_frame #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 5,
  parameter int PHY_AW  = 5,
  parameter int PRE_LEN = 32
) (
  input logic            mdc,
  input logic            rst,
  mdio_rx_frame_if.slave mdio
);
  localparam int MX = PRE_LEN > DATA_W ? PRE_LEN : DATA_W;
  localparam int CW = $clog2(MX + 1);
  localparam int AW = REG_AW > PHY_AW ? REG_AW : PHY_AW;
  localparam int SW = DATA_W > AW ? DATA_W : AW;
  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA_W, WDATA, TA_R, RDATA} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] pre_q, pre_d, cnt_q, cnt_d, lst;
  logic [SW-2:0] rx_q, rx_d;
  logic [SW-1:0] nxt;
  logic [DATA_W-1:0] tx_q, tx_d, wr_data_q, wr_data_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic is_wr_q, is_wr_d, match_q, match_d;
  logic wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, in_q, in_d, oe_q, oe_d, done_q, done_d, err_q, err_d;
  logic rx_phase, smp, adv, last, abort, pre_ok, shift;
  // TA_R and RDATA are driven by this block, so the generator's enable is irrelevant there
  assign rx_phase = state_q != TA_R && state_q != RDATA;
  assign smp      = mdio.mdio_oe && rx_phase;
  assign abort    = !mdio.mdio_oe && rx_phase && state_q != IDLE;
  assign adv      = smp || !rx_phase;
  assign nxt      = {rx_q, mdio.mdio_out};
  assign lst      = state_q == PHYAD ? CW'(PHY_AW - 1) : state_q == REGAD ? CW'(REG_AW - 1) :
                    state_q == WDATA || state_q == RDATA ? CW'(DATA_W - 1) : state_q == ST ? '0 : CW'(1);
  assign last     = adv && cnt_q == lst;
  assign shift    = state_q == TA_R ? last : state_q == RDATA && !last;
`ifdef MDIO_PRE_SUPPRESS_EN
  logic perm_q;
  always_ff @(posedge mdc) perm_q <= rst || err_d ? 1'b0 : done_d ? 1'b1 : perm_q;
  assign pre_ok = pre_q == CW'(PRE_LEN) || perm_q;
`else
  assign pre_ok = pre_q == CW'(PRE_LEN);
`endif
  always_ff @(posedge mdc)
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      match_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      in_q      <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      match_q   <= match_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      in_q      <= in_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else if (adv)
      case (state_q)
        IDLE:    state_d = !mdio.mdio_out && pre_ok ? ST : IDLE;
        ST:      state_d = mdio.mdio_out ? OP : IDLE;
        OP:      state_d = !last ? OP : nxt[1:0] == 2'b01 || nxt[1:0] == 2'b10 ? PHYAD : IDLE;
        PHYAD:   state_d = last ? REGAD : PHYAD;
        REGAD:   state_d = !last ? REGAD : is_wr_q ? TA_W : match_q ? TA_R : IDLE;
        TA_W:    state_d = !last ? TA_W : nxt[1:0] == 2'b10 ? WDATA : IDLE;
        WDATA:   state_d = last ? IDLE : WDATA;
        TA_R:    state_d = last ? RDATA : TA_R;
        RDATA:   state_d = last ? IDLE : RDATA;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    cnt_d     = state_d != state_q || state_q == IDLE ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    pre_d     = state_q != IDLE || (smp && !mdio.mdio_out) ? '0 :
                !smp || pre_q == CW'(PRE_LEN) ? pre_q : pre_q + 1'b1;
    rx_d      = smp ? nxt[SW-2:0] : rx_q;
    is_wr_d   = state_q == OP && last ? nxt[1:0] == 2'b01 : is_wr_q;
    match_d   = state_q == PHYAD && last ? nxt[PHY_AW-1:0] == mdio.phy_addr : match_q;
    addr_d    = state_q == REGAD && last ? nxt[REG_AW-1:0] : addr_q;
    rd_stb_d  = state_q == REGAD && state_d == TA_R;
    wr_stb_d  = state_q == WDATA && last && match_q;
    wr_data_d = wr_stb_d ? nxt[DATA_W-1:0] : wr_data_q;
    tx_d      = state_q == TA_R && !last ? mdio.rd_data : shift ? tx_q << 1 : tx_q;
    in_d      = shift && tx_q[DATA_W-1];
    oe_d      = state_q == TA_R || (state_q == RDATA && !last);
    done_d    = wr_stb_d || (state_q == RDATA && last);
    err_d     = abort || (smp && state_d == IDLE && (state_q == ST || state_q == OP || state_q == TA_W));
  end
  assign mdio.addr       = addr_q;
  assign mdio.wr_data    = wr_data_q;
  assign mdio.wr_stb     = wr_stb_q;
  assign mdio.rd_stb     = rd_stb_q;
  assign mdio.mdio_in    = in_q;
  assign mdio.mdio_in_oe = oe_q;
  assign mdio.mdio_done  = done_q;
  assign mdio.frame_err  = err_q;
endmodule

// File: doc/mdio_rx_frame.md
Name: mdio_rx_frame

Overview:
Second-generation MDIO management receiver (PHY side), clocked by MDC. It deserialises complete Clause-22 frames (preamble, ST, OP, PHYAD, REGAD, TA, data) from the station-manager generator and filters on a configurable PHY address. It issues one-cycle write/read strobes toward the register file and serialises read data back on mdio_in with turnaround control. It also flags malformed frames and adds parametrised widths, preamble length and address matching.

Parameters:
DATA_W, 16, data field width in bits (frame data phase length)
REG_AW, 5, register-address field width (REGAD)
PHY_AW, 5, PHY-address field width (PHYAD)
PRE_LEN, 32, minimum consecutive 1s accepted as a valid preamble

Ports:
mdc  in  1  MDIO management clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
phy_addr  in  PHY_AW  this device's PHY address, compared with PHYAD
mdio_out  in  1  serial bit from generator, valid when mdio_oe=1
mdio_oe  in  1  generator drive enable
rd_data  in  DATA_W  register-file read data, sampled one cycle after rd_stb
addr  out  REG_AW  register address (REGAD) of current frame
wr_data  out  DATA_W  write data
wr_stb  out  1  one-cycle write strobe
rd_stb  out  1  one-cycle read request
mdio_in  out  1  serial read data to generator
mdio_in_oe  out  1  high while this block drives mdio_in
mdio_done  out  1  one-cycle pulse at end of an accepted frame
frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset: all outputs 0, state IDLE, preamble counter 0, shift registers 0. rst has priority over all other activity, including a mid-frame read; mdio_in_oe is 0 after the reset edge.
- Sampling: the block samples mdio_out on each posedge while mdio_oe=1. Every state except TA_R and RDATA treats mdio_oe=0 as an abort: pulse frame_err (unless in IDLE), go to IDLE.
- IDLE: counts consecutive 1s, saturating at PRE_LEN. When a 0 arrives with count==PRE_LEN, go to ST. When a 0 arrives with count<PRE_LEN, clear the count and stay in IDLE, with no error.
- ST: expects 1 (second ST bit). A 0 pulses frame_err and returns to IDLE.
- OP: 2 bits MSB first. 01 is a write, 10 is a read. Any other value pulses frame_err after the second bit and returns to IDLE.
- PHYAD: PHY_AW bits MSB first. Match is evaluated on the last bit and stored.
- REGAD: REG_AW bits MSB first. On the last bit, addr is loaded.
  - Read with match: rd_stb=1 next cycle, go to TA_R.
  - Write: go to TA_W.
  - Read with no match: go to IDLE silently. The block never drives mdio_in_oe.
- TA_W: 2 bits, must be 10; otherwise frame_err and IDLE. Then go to WDATA.
- WDATA: DATA_W bits MSB first into a shift register. After the last bit:
  - Match: wr_data loaded, and wr_stb=1 plus mdio_done=1 for exactly one cycle.
  - No match: nothing.
  - Go to IDLE in both cases.
- TA_R: 2 cycles, mdio_oe ignored.
  - Cycle 1: rd_data latched into the output shift register; mdio_in_oe=0.
  - Cycle 2: mdio_in_oe=1, mdio_in=0.
- RDATA: DATA_W cycles with mdio_in_oe=1, mdio_in = latched data MSB first. After the last bit: mdio_in_oe=0, mdio_in=0, mdio_done=1 for one cycle, go to IDLE.
- Strobes:
  - wr_stb and rd_stb are never high in the same cycle.
  - addr holds its value until the next frame's REGAD completes.
  - wr_data holds until the next accepted write.
- The preamble counter restarts from 0 after every frame end or error. Back-to-back frames each need a full preamble unless the optional feature is enabled.
- Counters are sized ceil(log2(max(PRE_LEN,DATA_W)+1)) bits and never wrap.

Optional Feature:
MDIO_PRE_SUPPRESS_EN
- Defined: after the first accepted frame since reset, a 0 seen in IDLE with count<PRE_LEN also starts ST (preamble suppression). Any frame_err clears the permission until the next accepted frame.
- Undefined: a full PRE_LEN preamble is always required.

Test Plan:
- phy_addr=01, 32×1, ST=01, OP=01, PHYAD=01, REGAD=0A, TA=10, data=BEEF -> one cycle with wr_stb=1, mdio_done=1, addr=0A, wr_data=BEEF; rd_stb stays 0.
- Read: phy_addr=01, REGAD=03, rd_data=A5C3 -> rd_stb for 1 cycle; mdio_in_oe high for 17 cycles; mdio_in = 0, then 1010010111000011; then mdio_done pulse.
- Write frame with PHYAD=02, phy_addr=01 -> no wr_stb, mdio_done or frame_err; the next valid frame is accepted.
- 31 preamble 1s, then a valid frame body -> ignored, no strobes. The same frame with OP=11 and a full preamble -> frame_err pulse, no strobes.
- Write frame with TA=11 -> frame_err; mdio_oe dropped during WDATA -> frame_err; wr_stb stays 0 in both.
- rst asserted during RDATA bit 5 -> next edge mdio_in_oe=0, mdio_in=0, no mdio_done. With MDIO_PRE_SUPPRESS_EN, a second frame sent without preamble is accepted.
